// File: rtl/srl_fifo_reader.sv
// srl_fifo_reader: burst-coalescing read controller for an SRL FIFO, presenting words on a registered valid/ready stream
module srl_fifo_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int THRESH = 2,
  parameter int TIMEOUT = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_read_en,
  input  logic [WIDTH-1:0] fifo_read_data,
  input  logic             fifo_empty,
  input  logic [CW-1:0]    fifo_count,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             bursting,
  output logic             flushing,
  output logic [15:0]      word_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [WIDTH-1:0] skid_data;
  logic skid_valid, start, rd, take;
  assign start = fifo_count >= CW'(THRESH) || (!fifo_empty && timer == TW'(TIMEOUT - 1));
  // Reads stall on a full skid register, so out_ready never reaches fifo_read_en combinationally.
  assign fifo_read_en = !fifo_empty && (state == FLUSH || (state == BURST && !skid_valid));
  assign rd = fifo_read_en && state == BURST;
  assign take = out_valid && out_ready;
  assign bursting = state == BURST;
  assign flushing = state == FLUSH;
  always_comb begin
    state_nx = state;
    if (flush) state_nx = FLUSH;
    else if (state == IDLE) state_nx = start ? BURST : IDLE;
    else if (fifo_empty) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      skid_data <= '0;
      skid_valid <= 1'b0;
      word_count <= '0;
    end else begin
      state <= state_nx;
      timer <= (state == IDLE && state_nx == IDLE && !fifo_empty) ? timer + 1'b1 : '0;
      if (flush) begin
        out_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        if (take) word_count <= word_count + 1'b1;
        if (rd && (!out_valid || out_ready)) begin
          out_data <= fifo_read_data;
          out_valid <= 1'b1;
        end else if (rd) begin
          skid_data <= fifo_read_data;
          skid_valid <= 1'b1;
        end else if (take) begin
          out_data <= skid_valid ? skid_data : out_data;
          out_valid <= skid_valid;
          skid_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_srl_fifo_reader.sv
// tb_srl_fifo_reader: directed tests with a FIFO model and an output scoreboard
module tb_srl_fifo_reader;
  logic clk = 0, rst = 1;
  logic fifo_read_en, fifo_empty, flush = 0, out_valid, out_ready = 0, bursting, flushing;
  logic [7:0] fifo_read_data, out_data;
  logic [2:0] fifo_count;
  logic [15:0] word_count;
  logic wr_en = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] fmem [5];
  int fcnt = 0;
  logic [7:0] sb [$];
  logic [7:0] e_w;
  int total = 0, bad = 0, acc = 0;

  srl_fifo_reader #(.WIDTH(8), .DEPTH(4), .THRESH(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fifo_read_en(fifo_read_en), .fifo_read_data(fifo_read_data),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .bursting(bursting), .flushing(flushing),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // first-word fall-through FIFO model
  assign fifo_empty = fcnt == 0;
  assign fifo_count = 3'(fcnt);
  assign fifo_read_data = fmem[0];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      fmem[i] <= (wr_en && i == fcnt - (fifo_read_en ? 1 : 0)) ? wr_data : fifo_read_en ? fmem[i+1] : fmem[i];
    fcnt <= fcnt + (wr_en ? 1 : 0) - (fifo_read_en ? 1 : 0);
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      total++;
      acc++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL out_word unexpected got=%02h want=none", out_data);
      end else begin
        e_w = sb.pop_front();
        if (out_data !== e_w) begin
          bad++;
          $display("FAIL out_word got=%02h want=%02h", out_data, e_w);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input bit track);
    wr_en = 1;
    wr_data = d;
    if (track) sb.push_back(d);
    step();
    wr_en = 0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, quiet;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_read_en", fifo_read_en, 0);
    chk("rst_bursting", bursting, 0);
    chk("rst_flushing", flushing, 0);
    chk("rst_word_count", word_count, 0);
    step();
    rst = 0;
    step();
    // threshold burst
    out_ready = 1;
    put(8'h11, 1);
    put(8'h22, 1);
    chk("thr_idle_at_cnt2", bursting, 0);
    step();
    chk("thr_bursting", bursting, 1);
    chk("thr_read_en", fifo_read_en, 1);
    step();
    chk("thr_first", {out_valid, out_data}, 9'h111);
    step();
    chk("thr_second", {out_valid, out_data}, 9'h122);
    step();
    chk("thr_end_burst", bursting, 0);
    chk("thr_end_valid", out_valid, 0);
    chk("thr_word_count", word_count, 2);
    // timeout
    put(8'h5A, 1);
    quiet = 0;
    for (int i = 0; i < 16; i++) begin
      if (!fifo_read_en && !bursting) quiet++;
      step();
    end
    chk("to_quiet_cycles", quiet, 16);
    chk("to_burst_start", {bursting, fifo_read_en}, 2'b11);
    step();
    chk("to_delivered", {out_valid, out_data}, 9'h15A);
    step();
    chk("to_word_count", word_count, 3);
    // backpressure
    out_ready = 0;
    put(8'h01, 1);
    put(8'h02, 1);
    put(8'h03, 1);
    put(8'h04, 1);
    step();
    chk("bp_fifo_count", fifo_count, 2);
    chk("bp_read_en", fifo_read_en, 0);
    chk("bp_head", {out_valid, out_data}, 9'h101);
    step(); step(); step();
    chk("bp_hold_count", fifo_count, 2);
    chk("bp_hold_head", {out_valid, out_data, bursting}, 10'h203);
    out_ready = 1;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      step();
      n++;
    end
    chk("bp_drain_cycles", n, 4);
    chk("bp_fifo_empty", fifo_count, 0);
    chk("bp_out_idle", out_valid, 0);
    chk("bp_word_count", word_count, 7);
    // flush
    out_ready = 0;
    for (int i = 1; i <= 5; i++) put(8'hA0 + 8'(i), 0);
    chk("fl_pre_count", fifo_count, 3);
    chk("fl_pre_valid", out_valid, 1);
    flush = 1;
    step();
    flush = 0;
    chk("fl_valid_cleared", out_valid, 0);
    chk("fl_flushing", flushing, 1);
    n = 0;
    quiet = 0;
    while (flushing && n < 10) begin
      if (out_valid) quiet++;
      step();
      n++;
    end
    chk("fl_valid_during", quiet, 0);
    chk("fl_cycles", n, 4);
    chk("fl_fifo_count", fifo_count, 0);
    chk("fl_idle", {flushing, bursting}, 0);
    out_ready = 1;
    step(); step(); step();
    chk("fl_no_output", out_valid, 0);
    chk("fl_word_count", word_count, 7);
    // async reset mid-burst
    out_ready = 0;
    put(8'hB1, 1);
    put(8'hB2, 1);
    put(8'hB3, 1);
    put(8'hB4, 1);
    step();
    chk("ar_pre", {out_valid, bursting, fifo_count}, 5'b11010);
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_read_en", fifo_read_en, 0);
    chk("ar_bursting", bursting, 0);
    chk("ar_word_count", word_count, 0);
    chk("ar_fifo_kept", fifo_count, 2);
    void'(sb.pop_front());
    void'(sb.pop_front());
    step();
    rst = 0;
    out_ready = 1;
    drain("ar_drain", 30);
    chk("ar_after_count", word_count, 2);
    // counter wrap over 65537 words
    rst = 1;
    step();
    rst = 0;
    acc = 0;
    n = 0;
    while (n < 65537) begin
      wr_en = fcnt < 4;
      wr_data = 8'(n * 7);
      if (wr_en) begin
        sb.push_back(wr_data);
        n++;
      end
      step();
    end
    wr_en = 0;
    drain("wr_drain", 40);
    chk("wr_accepted", acc, 65537);
    chk("wr_word_count", word_count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
